// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// default latencies, counter width and sequencer states.
// Build option: MD_MADD_EN enables md_op 7 (MADD). When it is undefined,
// op 7 behaves exactly like NONE.
package md_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_MADD  = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W       = 4;

    // True for ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [2:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MD_MADD_EN
        r = r || (op == MD_MADD);
`endif
        return r;
    endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Latency down-counter. Loaded at issue and decremented every edge until it
// reaches zero. done is high in the cycle whose closing edge takes the count
// from 1 to 0, so the owner commits on that same edge.
module md_lat_counter
    import md_defs::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Load on issue, otherwise count down to zero and hold there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Terminal-count compare: the next edge takes the count to zero.
    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer. Owns HI/LO, models multi-cycle latency with a
// down-counter and drives md_out for MFHI/MFLO writeback.
// Build option: MD_MADD_EN adds MADD (op 7), a signed multiply-accumulate
// into {hi,lo} that uses the hi/lo values present at the commit edge.
//
// State  | Meaning
// -------+-------------------------------------------------------------
// S_IDLE | unit free; MTHI/MTLO write directly; long ops issue here
// S_RUN  | result held in pending register until the counter expires
module md_sequencer
    import md_defs::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_hi,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e        state;
    logic [63:0]      pend_res;
    logic             pend_wr;
    logic             pend_acc;

    logic             issue_long;
    logic             cnt_done;
    logic [CNT_W-1:0] lat_next;
    logic [63:0]      res_next;
    logic             wr_next;
    logic             acc_next;

    logic [31:0]      div_g;
    logic [31:0]      abs_a;
    logic [31:0]      abs_b;
    logic [31:0]      mag_q;
    logic [31:0]      mag_r;

    assign issue_long = (state == S_IDLE) && start && is_long_op(md_op);

    // Result of the op being issued. Signed divide works on magnitudes so the
    // 0x80000000 / -1 case wraps cleanly instead of relying on overflow.
    always_comb begin
        res_next = '0;
        wr_next  = 1'b1;
        acc_next = 1'b0;
        lat_next = CNT_W'(MUL_LAT);
        div_g    = (src_b == '0) ? 32'd1 : src_b;
        abs_a    = src_a[31] ? (~src_a + 32'd1) : src_a;
        abs_b    = src_b[31] ? (~src_b + 32'd1) : src_b;
        if (abs_b == '0) abs_b = 32'd1;
        mag_q    = abs_a / abs_b;
        mag_r    = abs_a % abs_b;
        case (md_op)
            MD_MULT: begin
                res_next = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
            end
            MD_MULTU: begin
                res_next = {32'd0, src_a} * {32'd0, src_b};
            end
            MD_DIV: begin
                lat_next = CNT_W'(DIV_LAT);
                wr_next  = (src_b != '0);
                res_next[31:0]  = (src_a[31] ^ src_b[31]) ? (~mag_q + 32'd1) : mag_q;
                res_next[63:32] = src_a[31] ? (~mag_r + 32'd1) : mag_r;
            end
            MD_DIVU: begin
                lat_next = CNT_W'(DIV_LAT);
                wr_next  = (src_b != '0);
                res_next = {src_a % div_g, src_a / div_g};
            end
`ifdef MD_MADD_EN
            MD_MADD: begin
                acc_next = 1'b1;
                res_next = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
            end
`endif
            default: ;
        endcase
    end

    md_lat_counter u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (issue_long),
        .load_val (lat_next),
        .done     (cnt_done)
    );

    // Sequencer: issue/capture in IDLE, commit pending result on counter expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            pend_res <= '0;
            pend_wr  <= 1'b0;
            pend_acc <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_long) begin
                        pend_res <= res_next;
                        pend_wr  <= wr_next;
                        pend_acc <= acc_next;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end else if (start && md_op == MD_MTHI) begin
                        hi <= src_a;
                    end else if (start && md_op == MD_MTLO) begin
                        lo <= src_a;
                    end
                end
                S_RUN: begin
                    if (cnt_done) begin
                        if (pend_wr) begin
                            if (pend_acc) {hi, lo} <= {hi, lo} + pend_res;
                            else          {hi, lo} <= pend_res;
                        end
                        pend_wr <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stall_req = busy | (start & is_long_op(md_op));
    assign md_out    = rd_hi ? hi : lo;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        rd_hi = 1'b0;
    logic        busy;
    logic        stall_req;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert = 0;
    int n_fail   = 0;
    int nb;

    md_sequencer #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .rd_hi     (rd_hi),
        .busy      (busy),
        .stall_req (stall_req),
        .md_out    (md_out),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start cycle; checks stall_req in the issue cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall, input string tag);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        #1;
        check({tag, "_stall_issue"}, {31'd0, stall_req}, {31'd0, exp_stall});
        tick();
        start = 1'b0;
        md_op = 3'd0;
    endtask

    // Count sampled cycles with busy high; bounded.
    task automatic wait_idle(output int n, input string tag);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (stall_req !== 1'b1) begin
                check({tag, "_stall_busy"}, {31'd0, stall_req}, 32'd1);
            end
            n++;
            tick();
        end
        check({tag, "_stall_done"}, {31'd0, stall_req}, 32'd0);
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        rd_hi = 1'b1;
        #1;
        check({tag, "_mdout_hi"}, md_out, eh);
        rd_hi = 1'b0;
        #1;
        check({tag, "_mdout_lo"}, md_out, el);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check_hilo("rst", 32'd0, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // MULT -2 * 3
        issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, "mult");
        wait_idle(nb, "mult");
        check("mult_busy_cycles", nb, 32'd5);
        check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        // DIVU 100 / 7
        issue(3'd4, 32'd100, 32'd7, 1'b1, "divu");
        wait_idle(nb, "divu");
        check("divu_busy_cycles", nb, 32'd10);
        check_hilo("divu", 32'd2, 32'd14);

        // DIV -7 / 2
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, "div");
        wait_idle(nb, "div");
        check("div_busy_cycles", nb, 32'd10);
        check_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        // DIV overflow case
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, "divovf");
        wait_idle(nb, "divovf");
        check_hilo("divovf", 32'd0, 32'h80000000);

        // MTHI / MTLO preload: single cycle, no busy
        issue(3'd5, 32'h11, 32'd0, 1'b0, "mthi");
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h22, 32'd0, 1'b0, "mtlo");
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        check_hilo("mtx", 32'h11, 32'h22);

        // NONE with start: no effect
        issue(3'd0, 32'hDEADBEEF, 32'd1, 1'b0, "none");
        check("none_busy", {31'd0, busy}, 32'd0);
        check_hilo("none", 32'h11, 32'h22);

        // Divide by zero: normal busy, hi/lo unchanged
        issue(3'd3, 32'd5, 32'd0, 1'b1, "div0");
        wait_idle(nb, "div0");
        check("div0_busy_cycles", nb, 32'd10);
        check_hilo("div0", 32'h11, 32'h22);

        // MULTU with MTLO issued at busy cycle 2 (ignored)
        issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b1, "multu");
        tick();
        start = 1'b1; md_op = 3'd6; src_a = 32'h55;
        tick();
        start = 1'b0; md_op = 3'd0;
        check("multu_mtlo_ignored", lo, 32'h22);
        check("multu_busy_mid", {31'd0, busy}, 32'd1);
        wait_idle(nb, "multu");
        check("multu_busy_rest", nb, 32'd3);
        check_hilo("multu", 32'd1, 32'hFFFFFFFE);

        // Op 7: MADD when enabled, otherwise NONE
        issue(3'd5, 32'd0, 32'd0, 1'b0, "madd_prehi");
        issue(3'd6, 32'hFFFFFFFF, 32'd0, 1'b0, "madd_prelo");
`ifdef MD_MADD_EN
        issue(3'd7, 32'd1, 32'd1, 1'b1, "madd");
        wait_idle(nb, "madd");
        check("madd_busy_cycles", nb, 32'd5);
        check_hilo("madd", 32'd1, 32'd0);
`else
        issue(3'd7, 32'd1, 32'd1, 1'b0, "op7");
        check("op7_busy", {31'd0, busy}, 32'd0);
        repeat (6) tick();
        check("op7_busy_late", {31'd0, busy}, 32'd0);
        check_hilo("op7", 32'd0, 32'hFFFFFFFF);
`endif

        // Reset at busy cycle 3 of a DIV
        issue(3'd6, 32'h77, 32'd0, 1'b0, "rstrun_pre");
        issue(3'd4, 32'd50, 32'd5, 1'b1, "rstrun");
        tick();
        tick();
        check("rstrun_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("rstrun_busy", {31'd0, busy}, 32'd0);
        check_hilo("rstrun", 32'd0, 32'd0);
        tick();
        reset = 1'b1;
        repeat (12) tick();
        check("rstrun_busy_after", {31'd0, busy}, 32'd0);
        check_hilo("rstrun_after", 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multiply/divide sequencer for the P6 five-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the EX stage and models the multi-cycle latency with a busy counter.
- Owns the HI/LO registers.
- Drives the MDout value that travels down the pipeline and is selected in writeback by Mem2Reg == 3.

Parameters:
- MUL_LAT, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_LAT, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately when low.
- start  input  1  issue strobe from EX-stage controller, valid for one cycle.
- md_op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD (MADD only with the optional feature).
- src_a  input  32  rs operand (forwarded value).
- src_b  input  32  rt operand (forwarded value).
- rd_hi  input  1  read select for MFHI (1) / MFLO (0).
- busy  output  1  operation in flight.
- stall_req  output  1  to hazard unit: busy | (start & md_op in {1..4,7}).
- md_out  output  32  rd_hi ? hi : lo (combinational).
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset values (reset low, asynchronous): hi=0, lo=0, busy=0, counter=0, pending result cleared. md_out=0 follows combinationally.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter>0).
- IDLE, start, op MULT/MULTU/DIV/DIVU:
  - Capture src_a/src_b and compute the 64-bit result into a pending register at that edge.
  - MULT: signed 32x32 product. MULTU: unsigned 32x32 product.
  - DIV/DIVU: lo=quotient, hi=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Load counter with MUL_LAT or DIV_LAT; go to RUN.
- RUN: counter decrements each edge. On the edge where counter goes 1->0:
  - Pending result commits to hi/lo.
  - busy deasserts on that same edge.
  - busy is therefore high for exactly LAT cycles; the result is visible on hi/lo/md_out in the first cycle busy=0.
- MTHI/MTLO with start in IDLE: hi (or lo) <= src_a on that edge. busy never asserts; single cycle.
- start while busy: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this via stall_req; the bench checks that state is unchanged.
- md_op NONE with start: no effect.
- Divide by zero (src_b=0, DIV/DIVU): busy sequence runs normally; hi/lo are left unchanged at commit.
- DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- Reset asserted mid-RUN: operation cancelled, no commit, outputs return to reset values; after release the block is IDLE.
- stall_req is combinational: high in the issue cycle and for all busy cycles, low in the commit-visible cycle.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: md_op 7 (MADD) is legal. {hi,lo} <= {hi,lo} + signed(src_a)*signed(src_b), 64-bit wrap, latency MUL_LAT. The accumulate uses the hi/lo values present at the commit edge.
- Undefined: md_op 7 is treated as NONE (no busy, no write).

Decomposition:
- Shared package md_defs: md_op encodings (MD_NONE..MD_MADD), default latencies, 4-bit counter width.
- One sub-module is natural: md_lat_counter (load value, decrement, done pulse on 1->0). The arithmetic stays in md_sequencer.

Test Plan:
- MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU 100/7, then DIV -7/2 -> hi=2, lo=14 after 10 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFD.
- DIV by zero with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy 10 cycles; hi/lo still 0x11/0x22.
- MULTU issued, then MTLO 0x55 issued at busy cycle 2 -> MTLO ignored; lo equals product low word at commit.
- Reset low at busy cycle 3 of DIV -> busy/hi/lo=0 immediately; no later commit.
- MD_MADD_EN defined, hi=0, lo=0xFFFFFFFF, MADD 1*1 -> hi=1, lo=0 after 5 cycles. Undefined: no busy, no change.
